// File: rtl/aes_inv_ks_pkg.sv
// Shared types and constants for the AES-128 inverse key schedule.
package aes_inv_ks_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_CALC,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_BYTES  = 16;
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_BYTES - 1);
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  // Round constant that was applied when producing round key r from r-1.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Load and round-key streaming handshakes of the inverse key schedule.
interface aes_inv_key_schedule_if;
  logic       start;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] rk_out;
  logic       rk_valid;
  logic       rk_ready;
  logic [3:0] rk_round;
  logic       rk_last;
  logic       done;
  logic       busy;

  modport master (
    output start, key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_valid, rk_round, rk_last, done, busy
  );

  modport slave (
    input  start, key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_valid, rk_round, rk_last, done, busy
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (table lookup).
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_s = SBOX[i_a];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: takes the round-10 key byte-serially and
// streams round keys 10 down to 0, regenerating each one in place with a
// single S-box over 16 cycles.
// Build option AES_INV_KS_ZEROIZE_EN: wipe the key register in DONE and
// drive rk_out to 0 whenever no round key is being presented.
module aes_inv_key_schedule
  import aes_inv_ks_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  aes_inv_key_schedule_if.slave   bus
);

  state_e           r_state;
  logic [3:0]       r_idx;
  logic [3:0]       r_round;
  logic [15:0][7:0] r_key;
  logic             r_key_ready;
  logic             r_rk_valid;
  logic [7:0]       r_rk_out;
  logic             r_rk_last;
  logic             r_done;
  logic             r_busy;

  logic [3:0]       w_pos;
  logic [7:0]       w_sbox_in;
  logic [7:0]       w_sbox_out;
  logic [7:0]       w_rcon;
  logic [7:0]       w_new_byte;
  logic             w_key_xfer;
  logic             w_rk_xfer;

  // CALC walks words 3,2,1,0 so every word update still sees the old lower word,
  // and word 0 sees the already-restored word 3 through RotWord.
  assign w_pos      = {~r_idx[3:2], r_idx[1:0]};
  assign w_sbox_in  = r_key[{2'b11, r_idx[1:0] + 2'd1}];
  assign w_rcon     = (r_idx[1:0] == 2'd0) ? rcon(r_round) : 8'h00;
  assign w_new_byte = (w_pos[3:2] == 2'b00) ? (r_key[w_pos] ^ w_sbox_out ^ w_rcon)
                                            : (r_key[w_pos] ^ r_key[w_pos - 4'd4]);
  assign w_key_xfer = r_key_ready & bus.key_valid;
  assign w_rk_xfer  = r_rk_valid & bus.rk_ready;

  aes_sbox u_sbox (
    .i_a (w_sbox_in),
    .o_s (w_sbox_out)
  );

  // Control FSM with registered handshake/status outputs and the key register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_round     <= '0;
      r_key       <= '0;
      r_key_ready <= 1'b0;
      r_rk_valid  <= 1'b0;
      r_rk_out    <= '0;
      r_rk_last   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_key_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_key_xfer) begin
            r_key[r_idx] <= bus.key_in;
            r_idx        <= r_idx + 4'd1;
            if (r_idx == LAST_IDX) begin
              r_key_ready <= 1'b0;
              r_round     <= LAST_ROUND;
              r_state     <= ST_EMIT;
              r_rk_valid  <= 1'b1;
              r_rk_out    <= r_key[0];
              r_rk_last   <= 1'b0;
            end
          end
        end
        ST_EMIT: begin
          if (w_rk_xfer) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == LAST_IDX) begin
              r_rk_valid <= 1'b0;
              r_rk_last  <= 1'b0;
`ifdef AES_INV_KS_ZEROIZE_EN
              r_rk_out   <= '0;
`endif
              if (r_round == 4'd0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_CALC;
              end
            end else begin
              r_rk_out  <= r_key[r_idx + 4'd1];
              r_rk_last <= (r_idx == LAST_IDX - 4'd1);
            end
          end
        end
        ST_CALC: begin
          r_key[w_pos] <= w_new_byte;
          r_idx        <= r_idx + 4'd1;
          if (r_idx == LAST_IDX) begin
            // byte 0 was rewritten at step 12, so it is final here
            r_round    <= r_round - 4'd1;
            r_state    <= ST_EMIT;
            r_rk_valid <= 1'b1;
            r_rk_out   <= r_key[0];
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`ifdef AES_INV_KS_ZEROIZE_EN
          r_key   <= '0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_ready = r_key_ready;
  assign bus.rk_valid  = r_rk_valid;
  assign bus.rk_out    = r_rk_out;
  assign bus.rk_round  = r_round;
  assign bus.rk_last   = r_rk_last;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule using FIPS-197 A.1 keys.
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if u_if();

  aes_inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // FIPS-197 A.1 expansion of 2b7e1516..., byte 0 in the MSBs.
  logic [127:0] RK [0:10];

  logic [7:0] gb [0:175];
  logic [3:0] gr [0:175];
  logic       gl [0:175];
  int         nb, cyc, viol;
  bit         aborted, got_done;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] kbyte(input int i);
    logic [127:0] k;
    k = RK[10];
    return k[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = v[127 - 8*k -: 8];
    return o;
  endfunction

  // Drive one run; stall_len idles key_valid after byte 7, start_at re-pulses
  // start at that emitted-byte count, abort5 returns once CALC of round 5 is seen.
  task automatic run(input bit rnd, input int stall_len, input int start_at, input bit abort5);
    int  bi = 0;
    int  stall = 0;
    bit  hold = 0;
    logic [7:0] ho = '0;
    logic [3:0] hr = '0;
    nb = 0; cyc = 0; viol = 0; aborted = 0; got_done = 0;
    for (int i = 0; i < 176; i++) begin gb[i] = '0; gr[i] = '0; gl[i] = 1'b0; end
    @(negedge clk);
    u_if.start = 1'b1; u_if.key_valid = 1'b1; u_if.key_in = kbyte(0); u_if.rk_ready = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      u_if.start = (start_at >= 0 && nb == start_at);
      if (u_if.done) begin got_done = 1; break; end
      if (abort5 && u_if.busy && !u_if.rk_valid && !u_if.key_ready && u_if.rk_round == 4'd5) begin
        aborted = 1; break;
      end
      if (hold && u_if.rk_valid && (u_if.rk_out !== ho || u_if.rk_round !== hr)) viol++;
      u_if.rk_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      hold = u_if.rk_valid && !u_if.rk_ready;
      ho = u_if.rk_out; hr = u_if.rk_round;
      if (u_if.rk_valid && u_if.rk_ready && nb < 176) begin
        gb[nb] = u_if.rk_out; gr[nb] = u_if.rk_round; gl[nb] = u_if.rk_last; nb++;
      end
      if (bi == 8 && stall < stall_len) begin u_if.key_valid = 1'b0; stall++; end
      else u_if.key_valid = 1'b1;
      u_if.key_in = kbyte(bi < 16 ? bi : 15);
      if (u_if.key_valid && u_if.key_ready) bi++;
    end
    u_if.start = 1'b0;
  endtask

  task automatic check_rounds(input string t);
    logic [127:0] v;
    int me = 0;
    chk({t, "_done_seen"}, got_done, 1);
    chk({t, "_nbytes"}, nb, 176);
    for (int r = 10; r >= 0; r--) begin
      for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = gb[(10 - r)*16 + k];
      chk($sformatf("%s_rk%0d", t, r), v, RK[r]);
    end
    for (int i = 0; i < 176; i++)
      if (gr[i] !== 4'(10 - i/16) || gl[i] !== (i % 16 == 15)) me++;
    chk({t, "_round_last"}, me, 0);
  endtask

  initial begin
    RK[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    RK[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    RK[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    RK[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    RK[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    RK[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    RK[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    RK[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    RK[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    RK[9]  = 128'hac7766f319fadc2128d12941575c006e;
    RK[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    u_if.start = 1'b0; u_if.key_in = '0; u_if.key_valid = 1'b0; u_if.rk_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_hs", {u_if.key_ready, u_if.rk_valid, u_if.rk_last}, 0);
    chk("rst_data", {u_if.rk_out, u_if.rk_round}, 0);
    chk("rst_status", {u_if.done, u_if.busy}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Nominal A.1 run
    run(0, 0, -1, 0);
    chk("a1_cycles", cyc, 353);
    check_rounds("a1");
    @(negedge clk);
    chk("a1_done_pulse", u_if.done, 0);
    chk("a1_busy_after", u_if.busy, 0);
`ifdef AES_INV_KS_ZEROIZE_EN
    chk("a1_key_reg", dut.r_key, 128'h0);
    chk("a1_rk_out_idle", u_if.rk_out, 8'h00);
`else
    chk("a1_key_reg", dut.r_key, bswap(RK[0]));
    chk("a1_rk_out_idle", u_if.rk_out, 8'h3c);
`endif

    // Random output backpressure
    run(1, 0, -1, 0);
    check_rounds("bp");
    chk("bp_stable", viol, 0);

    // Load stall after byte 7
    run(0, 5, -1, 0);
    chk("stall_cycles", cyc, 358);
    check_rounds("stall");

    // Reset during CALC of round 5
    run(0, 0, -1, 1);
    chk("abort_reached", aborted, 1);
    rst = 1'b0;
    #1;
    chk("abort_outs", {u_if.key_ready, u_if.rk_valid, u_if.rk_out, u_if.rk_round,
                       u_if.rk_last, u_if.done, u_if.busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_quiet", {u_if.rk_valid, u_if.busy, u_if.done}, 0);
    run(0, 0, -1, 0);
    chk("rerun_cycles", cyc, 353);
    check_rounds("rerun");

    // start pulsed during EMIT is ignored
    run(0, 0, 20, 0);
    chk("restart_cycles", cyc, 353);
    check_rounds("restart");
    begin
      int dc = 0;
      int bc = 0;
      repeat (400) begin
        @(negedge clk);
        if (u_if.done) dc++;
        if (u_if.busy || u_if.key_ready) bc++;
      end
      chk("restart_extra_done", dc, 0);
      chk("restart_idle", bc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
